diff_add_back: RTL
==================

Name: diff_add_back

Overview:
- Inverse of the team's 8-bit pixel subtractor in the noise-reduction datapath.
- Takes an 8-bit base pixel and a 9-bit two's-complement difference. The difference has the same format the subtractor produces, range -255..+255, and has been filtered and attenuated by the caller.
- Reconstructs the output pixel as base + (diff >>> SHIFT), clamped to 0..255.
- Pipelined with valid/ready flow control; sits between the edge-preserving filter kernel and the video output formatter.

Parameters:
- SHIFT, 0, arithmetic right-shift applied to diff before the add; legal range 0..8.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_base  in  8  unsigned base pixel (minuend of the original subtraction).
- in_diff  in  9  two's-complement difference; bit 8 is the sign.
- in_sof  in  1  start-of-frame marker, travels with the beat.
- in_eol  in  1  end-of-line marker, travels with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_pix  out  8  reconstructed, clamped pixel.
- out_sof  out  1  delayed in_sof.
- out_eol  out  1  delayed in_eol.
- sat_cnt  out  CNT_W  count of clamped beats in the current frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All pipeline valid flags = 0; out_valid = 0.
  - out_pix, out_sof, out_eol = 0; sat_cnt = 0.
  - in_ready is 1 one cycle after rst_n deasserts; 0 while in reset.
- Handshake:
  - A transfer occurs when valid && ready on a rising edge.
  - in_valid and payload must hold until accepted; out_valid and out_pix must hold stable while out_ready=0.
- Pipeline, 2 register stages, latency exactly 2 cycles from input accept to out_valid when not stalled:
  - S1: sign-extend in_diff to 10 bits, arithmetic shift right by SHIFT (the sign bit fills), zero-extend in_base to 10 bits, add into a 10-bit signed sum. Register the sum, sof, eol and v1.
  - S2: if sum < 0, out_pix = 0 and sat = 1; if sum > 255, out_pix = 255 and sat = 1; else out_pix = sum[7:0] and sat = 0. Register out_pix, out_sof, out_eol, out_valid.
- Flow control:
  - Standard ready-propagating pipeline: stage k advances when its output stage is empty or being drained.
  - in_ready = !v1 || (!out_valid || out_ready).
  - Full throughput of 1 beat/cycle with out_ready held at 1.
  - No bubble insertion and no beat loss or duplication under arbitrary out_ready toggling.
- Width rules: sum range is -255..+510, so 10-bit signed is sufficient. With SHIFT=8, a negative diff yields -1 and a non-negative diff yields 0.
- sat_cnt:
  - Updates when a beat leaves S2 (out_valid && out_ready).
  - If that beat has out_sof=1, sat_cnt loads sat (0 or 1); otherwise sat_cnt += sat.
  - Saturates at all-ones and never wraps.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both honoured.
  - sof on the draining beat takes priority over increment, i.e. the load value already includes that beat.
- Reset mid-frame discards in-flight beats; no partial outputs are produced afterwards.

Decomposition:
- Package diff_pkg: PIX_W=8, DIFF_W=9, SUM_W=10, PIX_MAX=255 constants; function clamp_pix(sum) returning {sat, pix}.
- One natural sub-module, pix_clamp (combinational S2 clamp), reused by other filter stages.
- The adder is written behaviourally, not as a chain of controlled-add/subtract cells.

Test Plan:
- SHIFT=0, out_ready=1: base=100, diff=9'h1E2 (-30) -> out_pix=70 exactly 2 cycles after accept, sat_cnt unchanged.
- SHIFT=0: base=10, diff=9'h1CE (-50) -> out_pix=0; base=250, diff=9'h014 (+20) -> out_pix=255; sat_cnt=2 after both. A following beat with sof=1 and no clamp -> sat_cnt=0.
- SHIFT=2: base=128, diff=9'h1F9 (-7) -> shifted -2, out_pix=126; diff=+7 -> out_pix=129.
- Round trip: for all 65536 (a,b) pairs, feed base=b and diff=a-b as produced by the subtractor, SHIFT=0 -> out_pix==a, sat_cnt never increments.
- Backpressure: stream 20 beats with out_ready random 50% -> output sequence equals the input sequence in order, no drops or duplicates, out_pix stable while stalled. With out_ready=1, in_ready stays 1 every cycle.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, sat_cnt=0, no stale beat after release.

Source files
------------

// File: rtl/diff_pkg.sv
// Shared widths and the pixel clamp used by the add-back stage and other filter stages.
package diff_pkg;

    localparam int PIX_W  = 8;
    localparam int DIFF_W = 9;
    localparam int SUM_W  = 10;
    localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

    // Returns {sat, pix}: sat is set whenever the sum had to be clamped.
    function automatic logic [PIX_W:0] clamp_pix(input logic signed [SUM_W-1:0] sum);
        logic [PIX_W:0] r;
        if (sum < 0) begin
            r = {1'b1, {PIX_W{1'b0}}};
        end else if (sum > 10'sd255) begin
            r = {1'b1, PIX_MAX};
        end else begin
            r = {1'b0, sum[PIX_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/diff_add_back_clamp.sv
// Combinational clamp of a signed sum onto the 0..255 pixel range.
module pix_clamp
    import diff_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum_i,
    output logic [PIX_W-1:0]        pix_o,
    output logic                    sat_o
);

    assign {sat_o, pix_o} = clamp_pix(sum_i);

endmodule

// File: rtl/diff_add_back.sv
// Reconstructs base + (diff >>> SHIFT) clamped to 0..255 through a two-stage
// valid/ready pipeline and counts clamped beats per frame.
module diff_add_back
    import diff_pkg::*;
#(
    parameter int SHIFT = 0,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_base,
    input  logic [DIFF_W-1:0] in_diff,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic              out_sof,
    output logic              out_eol,
    output logic [CNT_W-1:0]  sat_cnt
);

    // Handshake: a beat moves on a rising edge where valid && ready; a stage
    // loads when it is empty or its current beat leaves in the same cycle.
    logic                    rdy_q, rdy_d;
    logic                    v1_q, v1_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    sof1_q, sof1_d, eol1_q, eol1_d;
    logic                    v2_q, v2_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic                    sof2_q, sof2_d, eol2_q, eol2_d;
    logic                    sat2_q, sat2_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [SUM_W-1:0] diff_ext, diff_sh, base_ext, sum_s1;
    logic [PIX_W-1:0]        clamp_pix_w;
    logic                    clamp_sat_w;
    logic                    adv1, adv2, drain;

    assign diff_ext = signed'({in_diff[DIFF_W-1], in_diff});
    assign diff_sh  = diff_ext >>> SHIFT;
    assign base_ext = signed'({2'b00, in_base});
    assign sum_s1   = diff_sh + base_ext;

    pix_clamp u_clamp (
        .sum_i (sum_q),
        .pix_o (clamp_pix_w),
        .sat_o (clamp_sat_w)
    );

    assign adv2     = !v2_q || out_ready;
    assign adv1     = rdy_q && (!v1_q || adv2);
    assign drain    = v2_q && out_ready;
    assign in_ready = adv1;

    always_comb begin
        rdy_d  = 1'b1;
        v1_d   = v1_q;
        sum_d  = sum_q;
        sof1_d = sof1_q;
        eol1_d = eol1_q;
        v2_d   = v2_q;
        pix_d  = pix_q;
        sof2_d = sof2_q;
        eol2_d = eol2_q;
        sat2_d = sat2_q;
        cnt_d  = cnt_q;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                sum_d  = sum_s1;
                sof1_d = in_sof;
                eol1_d = in_eol;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                pix_d  = clamp_pix_w;
                sat2_d = clamp_sat_w;
                sof2_d = sof1_q;
                eol2_d = eol1_q;
            end
        end

        // A frame start restarts the count with the draining beat already included.
        if (drain) begin
            if (sof2_q) begin
                cnt_d = CNT_W'(sat2_q);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(sat2_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            v1_q   <= 1'b0;
            sum_q  <= '0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            v2_q   <= 1'b0;
            pix_q  <= '0;
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
            sat2_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            rdy_q  <= rdy_d;
            v1_q   <= v1_d;
            sum_q  <= sum_d;
            sof1_q <= sof1_d;
            eol1_q <= eol1_d;
            v2_q   <= v2_d;
            pix_q  <= pix_d;
            sof2_q <= sof2_d;
            eol2_q <= eol2_d;
            sat2_q <= sat2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = v2_q;
    assign out_pix   = pix_q;
    assign out_sof   = sof2_q;
    assign out_eol   = eol2_q;
    assign sat_cnt   = cnt_q;

endmodule
